// File: rtl/output_tile_scheduler_pkg.sv
// Shared definitions for the output tile scheduler and its helpers.
//   - state_e        : scheduler FSM encoding
//   - DEF_*          : default geometry of the result matrix / systolic array
//   - NUM_SUBMATS_M/N: tile grid size for the default geometry
//   - LOG_ROWS/COLS  : log2 of the systolic array dimensions (default geometry)
//   - clog2_min1()   : $clog2 clamped to at least 1 bit, for counter widths
package output_tile_scheduler_pkg;

  localparam int DEF_MAX_OUT_ROWS = 128;
  localparam int DEF_MAX_OUT_COLS = 128;
  localparam int DEF_SYS_ARR_ROWS = 16;
  localparam int DEF_SYS_ARR_COLS = 16;
  localparam int DEF_ADDR_WIDTH   = 8;

  localparam int NUM_SUBMATS_M = DEF_MAX_OUT_ROWS / DEF_SYS_ARR_ROWS;
  localparam int NUM_SUBMATS_N = DEF_MAX_OUT_COLS / DEF_SYS_ARR_COLS;
  localparam int LOG_ROWS      = $clog2(DEF_SYS_ARR_ROWS);
  localparam int LOG_COLS      = $clog2(DEF_SYS_ARR_COLS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  // A single-tile grid still needs a 1-bit counter.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/output_tile_scheduler_tile_counter2d.sv
// tile_counter2d: row-major 2-D tile counter.
//   clk, reset   : clock, synchronous active-high reset
//   clear_i      : restart at tile (0,0)
//   adv_i        : step to the next tile (column first, wrap into next row)
//   last_row_i   : index of the final tile row
//   last_col_i   : index of the final tile column
//   row_o, col_o : current tile coordinates
//   last_o       : current tile is the final one of the grid
module tile_counter2d #(
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             adv_i,
  input  logic [ROW_W-1:0] last_row_i,
  input  logic [COL_W-1:0] last_col_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_o
);

  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (adv_i) begin
      if (col_q == last_col_i) begin
        col_q <= '0;
        row_q <= row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == last_row_i) && (col_q == last_col_i);

endmodule

// File: rtl/output_tile_scheduler.sv
// output_tile_scheduler: walks every output tile of a result matrix in
// row-major order, issuing one store-controller start per tile and waiting
// for it to go idle, then pulses done.
//   clk, reset                   : clock, synchronous active-high reset
//   start                        : one-cycle request, ignored while busy
//   out_rows_m1, out_cols_m1     : matrix size minus one (latched at start)
//   base_addr                    : write address of tile (0,0) (latched)
//   activate, clear_after        : per-run store options (latched)
//   busy, done                   : run in progress / one-cycle completion
//   st_start                     : store-controller start pulse
//   st_done                      : store-controller idle level
//   st_submat_row/col            : current tile coordinates
//   st_num_rows_read/cols_read   : tile extent minus one (edge tiles shrink)
//   st_wr_base_addr              : tile write base address
//   st_activate, st_clear_after  : latched run options
module output_tile_scheduler
  import output_tile_scheduler_pkg::*;
#(
  parameter int MAX_OUT_ROWS = DEF_MAX_OUT_ROWS,
  parameter int MAX_OUT_COLS = DEF_MAX_OUT_COLS,
  parameter int SYS_ARR_ROWS = DEF_SYS_ARR_ROWS,
  parameter int SYS_ARR_COLS = DEF_SYS_ARR_COLS,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  localparam int RW  = $clog2(MAX_OUT_ROWS),
  localparam int CW  = $clog2(MAX_OUT_COLS),
  localparam int LR  = $clog2(SYS_ARR_ROWS),
  localparam int LC  = $clog2(SYS_ARR_COLS),
  localparam int TRW = clog2_min1(MAX_OUT_ROWS / SYS_ARR_ROWS),
  localparam int TCW = clog2_min1(MAX_OUT_COLS / SYS_ARR_COLS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [RW-1:0]         out_rows_m1,
  input  logic [CW-1:0]         out_cols_m1,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  activate,
  input  logic                  clear_after,
  output logic                  busy,
  output logic                  done,
  output logic                  st_start,
  input  logic                  st_done,
  output logic [TRW-1:0]        st_submat_row,
  output logic [TCW-1:0]        st_submat_col,
  output logic [LR-1:0]         st_num_rows_read,
  output logic [LC-1:0]         st_num_cols_read,
  output logic [ADDR_WIDTH-1:0] st_wr_base_addr,
  output logic                  st_activate,
  output logic                  st_clear_after
);

  state_e                state_q, state_d;
  logic [RW-1:0]         rows_q, rows_d;
  logic [CW-1:0]         cols_q, cols_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  act_q, act_d;
  logic                  clr_q, clr_d;
  logic                  cnt_clear, cnt_adv, tile_last;
  logic [TRW-1:0]        last_row, cur_row;
  logic [TCW-1:0]        last_col, cur_col;

  assign last_row = TRW'(rows_q >> LR);
  assign last_col = TCW'(cols_q >> LC);

  tile_counter2d #(.ROW_W(TRW), .COL_W(TCW)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (cnt_clear),
    .adv_i      (cnt_adv),
    .last_row_i (last_row),
    .last_col_i (last_col),
    .row_o      (cur_row),
    .col_o      (cur_col),
    .last_o     (tile_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      addr_q  <= '0;
      act_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      addr_q  <= addr_d;
      act_q   <= act_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    addr_d    = addr_q;
    act_d     = act_q;
    clr_d     = clr_q;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        rows_d    = out_rows_m1;
        cols_d    = out_cols_m1;
        addr_d    = base_addr;
        act_d     = activate;
        clr_d     = clear_after;
        cnt_clear = 1'b1;
        state_d   = S_ISSUE;
      end
      S_ISSUE: state_d = S_ARM;
      // The store controller still reports idle the cycle after its start.
      S_ARM:   state_d = S_WAIT;
      S_WAIT: if (st_done) begin
        if (tile_last) begin
          state_d = S_FIN;
        end else begin
          cnt_adv = 1'b1;
          addr_d  = addr_q + ADDR_WIDTH'(SYS_ARR_ROWS);
          state_d = S_ISSUE;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs decode registered state only; st_done never reaches them.
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_FIN);
  assign st_start         = (state_q == S_ISSUE);
  assign st_submat_row    = cur_row;
  assign st_submat_col    = cur_col;
  assign st_num_rows_read = (cur_row == last_row) ? rows_q[LR-1:0] : '1;
  assign st_num_cols_read = (cur_col == last_col) ? cols_q[LC-1:0] : '1;
  assign st_wr_base_addr  = addr_q;
  assign st_activate      = act_q;
  assign st_clear_after   = clr_q;

endmodule
